// File: rtl/arp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : arp_ctrl
//  Purpose  : ARP sequencing controller. Answers incoming ARP requests, keeps
//             a single-entry peer cache and resolves destination IPs for the
//             UDP sender with timed, bounded request retries. Owns the single
//             ARP transmit framer and arbitrates it between replies and
//             requests.
//  Revision : 1.0  initial release
// ============================================================================
module arp_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125_000_000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        resolve_done,
    output logic        resolve_fail,
    output logic [47:0] resolved_mac,
    output logic        cache_valid,
    output logic [31:0] cache_ip,
    output logic [47:0] cache_mac,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        arp_tx_done
);

    localparam logic [47:0] c_BCAST_MAC = 48'hffff_ffff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_reply_pend;
    logic [47:0] r_reply_mac;
    logic [31:0] r_reply_ip;
    logic        r_resolve_pend;
    logic [31:0] r_tgt_ip;
    logic        r_busy;        // a resolve owns the FSM (request issued, no verdict yet)
    logic [31:0] r_retry_cnt;
    logic [31:0] r_timer;

    logic        w_cache_hit;
    logic        w_rx_match;
    logic        w_timeout;
    logic        w_issue_reply;
    logic        w_start_req;   // first request of a resolve, issued from IDLE
    logic        w_retry_req;   // re-issued request after a timeout
    logic        w_hit_done;
    logic        w_match_done;
    logic        w_fail;

    assign w_cache_hit = cache_valid && (cache_ip == r_tgt_ip);
    assign w_rx_match  = arp_rx_done && arp_rx_type && (src_ip == r_tgt_ip);
    // >= so that a timeout that elapsed during a reply transmission is still seen
    assign w_timeout   = (r_timer >= (TIMEOUT_CYCLES - 32'd1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and action decode: replies first, then cache hits, then requests
    always_comb begin
        w_state_nxt   = r_state;
        w_issue_reply = 1'b0;
        w_start_req   = 1'b0;
        w_retry_req   = 1'b0;
        w_hit_done    = 1'b0;
        w_match_done  = 1'b0;
        w_fail        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_reply_pend) begin
                    w_issue_reply = 1'b1;
                    w_state_nxt   = ST_TX;
                end else if (r_resolve_pend) begin
                    if (w_cache_hit) begin
                        w_hit_done = 1'b1;
                    end else begin
                        w_start_req = 1'b1;
                        w_state_nxt = ST_TX;
                    end
                end
            end
            ST_TX: begin
                if (arp_tx_done) begin
                    w_state_nxt = r_busy ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_rx_match) begin
                    w_match_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (w_timeout) begin
                    if (r_retry_cnt < MAX_RETRY) begin
                        w_retry_req = 1'b1;
                        w_state_nxt = ST_TX;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_reply_pend) begin
                    w_issue_reply = 1'b1;
                    w_state_nxt   = ST_TX;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending work: a new request arriving while a reply is issued wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reply_pend   <= 1'b0;
            r_reply_mac    <= '0;
            r_reply_ip     <= '0;
            r_resolve_pend <= 1'b0;
            r_tgt_ip       <= '0;
        end else begin
            if (arp_rx_done && !arp_rx_type) begin
                r_reply_pend <= 1'b1;
                r_reply_mac  <= src_mac;
                r_reply_ip   <= src_ip;
            end else if (w_issue_reply) begin
                r_reply_pend <= 1'b0;
            end
            if (resolve_req && !r_resolve_pend && !r_busy) begin
                r_resolve_pend <= 1'b1;
                r_tgt_ip       <= resolve_ip;
            end else if (w_hit_done || w_start_req) begin
                r_resolve_pend <= 1'b0;
            end
        end
    end

    // Single-entry peer cache, overwritten by every accepted ARP packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_ip    <= '0;
            cache_mac   <= '0;
        end else if (arp_rx_done) begin
            cache_valid <= 1'b1;
            cache_ip    <= src_ip;
            cache_mac   <= src_mac;
        end
    end

    // Resolve progress: ownership flag, attempt counter and per-attempt timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_retry_cnt <= '0;
            r_timer     <= '0;
        end else begin
            if (w_start_req) begin
                r_busy <= 1'b1;
            end else if (w_match_done || w_fail) begin
                r_busy <= 1'b0;
            end
            if (w_start_req) begin
                r_retry_cnt <= '0;
            end else if (w_retry_req) begin
                r_retry_cnt <= r_retry_cnt + 32'd1;
            end
            if (w_start_req || w_retry_req) begin
                r_timer <= '0;
            end else if (r_busy && (r_state != ST_IDLE)) begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    // Registered outputs: framer command and resolve verdict pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arp_tx_en    <= 1'b0;
            arp_tx_type  <= 1'b0;
            des_mac      <= '0;
            des_ip       <= '0;
            resolve_done <= 1'b0;
            resolve_fail <= 1'b0;
            resolved_mac <= '0;
        end else begin
            arp_tx_en    <= w_issue_reply || w_start_req || w_retry_req;
            resolve_done <= w_hit_done || w_match_done;
            resolve_fail <= w_fail;
            if (w_issue_reply) begin
                arp_tx_type <= 1'b1;
                des_mac     <= r_reply_mac;
                des_ip      <= r_reply_ip;
            end else if (w_start_req || w_retry_req) begin
                arp_tx_type <= 1'b0;
                des_mac     <= c_BCAST_MAC;
                des_ip      <= r_tgt_ip;
            end
            if (w_hit_done) begin
                resolved_mac <= cache_mac;
            end else if (w_match_done) begin
                resolved_mac <= src_mac;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arp_ctrl
//  Purpose  : Self-checking bench for arp_ctrl. Transaction-level scoreboard
//             of expected framer commands and resolve verdicts, a peer-cache
//             model, a responding framer, directed scenarios and a random
//             scenario loop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        resolve_req = 1'b0;
    logic [31:0] resolve_ip = '0;
    logic        resolve_done;
    logic        resolve_fail;
    logic [47:0] resolved_mac;
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        arp_tx_done = 1'b0;

    arp_ctrl #(
        .TIMEOUT_CYCLES(32'd100),
        .MAX_RETRY     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .resolve_req (resolve_req),
        .resolve_ip  (resolve_ip),
        .resolve_done(resolve_done),
        .resolve_fail(resolve_fail),
        .resolved_mac(resolved_mac),
        .cache_valid (cache_valid),
        .cache_ip    (cache_ip),
        .cache_mac   (cache_mac),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .arp_tx_done (arp_tx_done)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

    typedef struct packed {
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } frame_t;

    typedef struct packed {
        logic        fail;
        logic [47:0] mac;
    } verdict_t;

    frame_t      exp_tx[$];
    verdict_t    exp_res[$];
    int          tx_cyc_q[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_tx = 0;
    int          n_done = 0;
    int          n_fail = 0;
    int          last_done_cyc = 0;
    int          last_fail_cyc = 0;
    int          fr_lat = 5;
    bit          out_valid = 0;
    frame_t      out_f;
    frame_t      last_tx_f;
    logic [47:0] m_resolved = '0;

    // Peer-cache model: every received ARP packet replaces the single entry
    logic        m_cvalid;
    logic [31:0] m_cip;
    logic [47:0] m_cmac;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cvalid <= 1'b0;
            m_cip    <= '0;
            m_cmac   <= '0;
        end else if (arp_rx_done) begin
            m_cvalid <= 1'b1;
            m_cip    <= src_ip;
            m_cmac   <= src_mac;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the scoreboard and cache model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_valid  = 0;
                m_resolved = '0;
            end else begin
                chk("cache_valid", 96'(cache_valid), 96'(m_cvalid));
                chk("cache_ip", 96'(cache_ip), 96'(m_cip));
                chk("cache_mac", 96'(cache_mac), 96'(m_cmac));
                if (resolve_done || resolve_fail) begin
                    if (exp_res.size() == 0) begin
                        chk("unexpected_verdict", 96'({resolve_done, resolve_fail}), 96'(0));
                    end else begin
                        verdict_t v;
                        v = exp_res.pop_front();
                        chk("verdict_kind", 96'({resolve_done, resolve_fail}),
                            v.fail ? 96'(2'b01) : 96'(2'b10));
                        if (!v.fail) m_resolved = v.mac;
                    end
                    if (resolve_done) begin n_done++; last_done_cyc = cyc; end
                    if (resolve_fail) begin n_fail++; last_fail_cyc = cyc; end
                end
                chk("resolved_mac", 96'(resolved_mac), 96'(m_resolved));
                if (arp_tx_en) begin
                    n_tx++;
                    tx_cyc_q.push_back(cyc);
                    last_tx_f = {arp_tx_type, des_mac, des_ip};
                    if (exp_tx.size() == 0) begin
                        chk("unexpected_tx", 96'(arp_tx_en), 96'(0));
                    end else begin
                        frame_t f;
                        f = exp_tx.pop_front();
                        chk("tx_frame", 96'(last_tx_f), 96'(f));
                    end
                    out_valid = 1;
                    out_f     = last_tx_f;
                end else if (out_valid) begin
                    chk("tx_stable", 96'({arp_tx_type, des_mac, des_ip}), 96'(out_f));
                    if (arp_tx_done) out_valid = 0;
                end
            end
        end
    end

    // Framer: acknowledges each start pulse fr_lat cycles later; reset aborts it
    initial begin
        bit alive;
        forever begin
            @(negedge clk);
            if (rst_n && arp_tx_en) begin
                alive = 1;
                for (int i = 0; i < fr_lat; i++) begin
                    @(posedge clk);
                    if (!rst_n) alive = 0;
                end
                if (alive) begin
                    #1 arp_tx_done = 1'b1;
                    @(posedge clk);
                    #1 arp_tx_done = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rx_pkt(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                          input bit exp_reply);
        frame_t f;
        if (exp_reply) begin
            f = {1'b1, mac, ip};
            exp_tx.push_back(f);
        end
        arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = mac; src_ip = ip;
        tick(1);
        arp_rx_done = 1'b0; arp_rx_type = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] ip);
        resolve_req = 1'b1; resolve_ip = ip;
        tick(1);
        resolve_req = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] ip, input int count);
        frame_t f;
        f = {1'b0, BCAST, ip};
        repeat (count) exp_tx.push_back(f);
    endtask

    task automatic push_verdict(input bit fail, input logic [47:0] mac);
        verdict_t v;
        v = {fail, mac};
        exp_res.push_back(v);
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while ((exp_tx.size() != 0 || exp_res.size() != 0 || out_valid) && t < budget) begin
            tick(1); t++;
        end
        chk("quiet_timeout", 96'(t >= budget), 96'(0));
        if (t >= budget) begin exp_tx.delete(); exp_res.delete(); end
        tick(3);
    endtask

    // Wait until `target` frames were issued and the last one was acknowledged
    task automatic wait_tx(input int target, input int budget);
        int t = 0;
        while ((n_tx < target || out_valid) && t < budget) begin tick(1); t++; end
        chk("wait_tx_timeout", 96'(t >= budget), 96'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pulses"}, 96'({resolve_done, resolve_fail, arp_tx_en, arp_tx_type, cache_valid}), 96'(0));
        chk({tag, "_macs"}, 96'({resolved_mac, cache_mac}), 96'(0));
        chk({tag, "_des"}, 96'({des_mac, des_ip}), 96'(0));
        chk({tag, "_cache_ip"}, 96'(cache_ip), 96'(0));
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    initial begin
        int base, s, kind, k;
        logic [31:0] ip;
        logic [47:0] mac;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        while (cyc < 3) tick(1);
        rst_n = 1'b1;
        while (cyc < 10) tick(1);

        // Incoming request answered two cycles later
        rx_pkt(1'b0, 48'ha0b1c2d3e4f5, 32'hc0a80102, 1);
        wait_quiet(200);
        chk("reply_en_cycle", 96'(tx_cyc_q[0]), 96'(12));
        chk("reply_type", 96'(last_tx_f.typ), 96'(1));
        chk("reply_mac", 96'(last_tx_f.mac), 96'(48'ha0b1c2d3e4f5));
        chk("reply_ip", 96'(last_tx_f.ip), 96'(32'hc0a80102));
        chk("learn_ip", 96'({cache_valid, cache_ip}), 96'({1'b1, 32'hc0a80102}));

        // Cache hit: verdict two cycles after the request, no frame
        base = n_tx;
        push_verdict(0, 48'ha0b1c2d3e4f5);
        s = cyc;
        resolve(32'hc0a80102);
        wait_quiet(50);
        chk("hit_done_cycle", 96'(last_done_cyc), 96'(s + 2));
        chk("hit_mac", 96'(resolved_mac), 96'(48'ha0b1c2d3e4f5));
        chk("hit_no_tx", 96'(n_tx), 96'(base));

        // Cache miss, slow framer, matching reply
        fr_lat = 60;
        base = n_tx;
        push_req(32'hc0a80103, 1);
        resolve(32'hc0a80103);
        wait_tx(base + 1, 200);
        chk("miss_des_mac", 96'(last_tx_f.mac), 96'(48'hffffffffffff));
        chk("miss_des_ip", 96'({last_tx_f.typ, last_tx_f.ip}), 96'({1'b0, 32'hc0a80103}));
        tick(5);
        push_verdict(0, 48'h112233445566);
        s = cyc;
        rx_pkt(1'b1, 48'h112233445566, 32'hc0a80103, 0);
        wait_quiet(100);
        chk("miss_done_cycle", 96'(last_done_cyc), 96'(s + 1));
        chk("miss_mac", 96'(resolved_mac), 96'(48'h112233445566));
        chk("miss_learn", 96'(cache_mac), 96'(48'h112233445566));

        // Retry exhaustion: three requests 100 cycles apart, then one fail
        fr_lat = 10;
        base = n_tx;
        k = n_fail;
        push_req(32'hc0a801aa, 3);
        push_verdict(1, '0);
        resolve(32'hc0a801aa);
        wait_quiet(600);
        chk("retry_count", 96'(n_tx - base), 96'(3));
        chk("retry_gap1", 96'(tx_cyc_q[base + 1] - tx_cyc_q[base]), 96'(100));
        chk("retry_gap2", 96'(tx_cyc_q[base + 2] - tx_cyc_q[base + 1]), 96'(100));
        chk("fail_cycle", 96'(last_fail_cyc), 96'(tx_cyc_q[base + 2] + 100));
        chk("fail_count", 96'(n_fail - k), 96'(1));

        // Request answered mid-resolve; a second resolve_req is ignored meanwhile
        fr_lat = 3;
        base = n_tx;
        push_req(32'hc0a80110, 1);
        resolve(32'hc0a80110);
        wait_tx(base + 1, 50);
        resolve(32'hc0a80177);
        tick(1);
        rx_pkt(1'b0, 48'h0a0b0c0d0e0f, 32'hc0a80120, 1);
        wait_tx(base + 2, 50);
        chk("mid_reply_type", 96'(last_tx_f.typ), 96'(1));
        tick(2);
        push_verdict(0, 48'h665544332211);
        rx_pkt(1'b1, 48'h665544332211, 32'hc0a80110, 0);
        wait_quiet(100);
        chk("mid_done_mac", 96'(resolved_mac), 96'(48'h665544332211));

        // Simultaneous request and resolve of the same IP: reply first, then a hit
        base = n_tx;
        exp_tx.push_back({1'b1, 48'hdeadbeef0001, 32'h0a000001});
        push_verdict(0, 48'hdeadbeef0001);
        s = cyc;
        arp_rx_done = 1'b1; arp_rx_type = 1'b0; src_mac = 48'hdeadbeef0001; src_ip = 32'h0a000001;
        resolve_req = 1'b1; resolve_ip = 32'h0a000001;
        tick(1);
        arp_rx_done = 1'b0; resolve_req = 1'b0;
        wait_quiet(100);
        chk("simul_tx_cycle", 96'(tx_cyc_q[base]), 96'(s + 2));
        chk("simul_one_tx", 96'(n_tx - base), 96'(1));
        chk("simul_done_after", 96'(last_done_cyc > tx_cyc_q[base]), 96'(1));

        // Latest request wins while the framer is busy
        fr_lat = 30;
        base = n_tx;
        rx_pkt(1'b0, 48'h00000000a001, 32'h0a0000a1, 1);
        while (n_tx < base + 1) tick(1);
        rx_pkt(1'b0, 48'h00000000b002, 32'h0a0000b2, 0);
        tick(2);
        rx_pkt(1'b0, 48'h00000000c003, 32'h0a0000c3, 1);
        wait_quiet(200);
        chk("latest_ip", 96'(last_tx_f.ip), 96'(32'h0a0000c3));

        // Random scenarios
        for (int it = 0; it < 30; it++) begin
            fr_lat = $urandom_range(1, 30);
            kind = $urandom_range(0, 4);
            mac = rnd48();
            ip = $urandom;
            while (ip == m_cip) ip = $urandom;
            base = n_tx;
            case (kind)
                0: rx_pkt(1'b0, mac, ip, 1);
                1: if (m_cvalid) begin
                       push_verdict(0, m_cmac);
                       resolve(m_cip);
                   end
                2: begin
                       k = $urandom_range(1, 3);
                       push_req(ip, k);
                       push_verdict(0, mac);
                       resolve(ip);
                       wait_tx(base + k, 400);
                       tick($urandom_range(1, 40));
                       rx_pkt(1'b1, mac, ip, 0);
                   end
                3: begin
                       push_req(ip, 3);
                       push_verdict(1, '0);
                       resolve(ip);
                   end
                default: rx_pkt(1'b1, mac, ip, 0);
            endcase
            wait_quiet(600);
            tick($urandom_range(0, 3));
        end

        // Reset during a request transmission
        fr_lat = 50;
        base = n_tx;
        push_req(32'hc0a801ee, 1);
        resolve(32'hc0a801ee);
        while (n_tx < base + 1) tick(1);
        tick(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        exp_tx.delete();
        exp_res.delete();
        tick(3);
        rst_n = 1'b1;
        base = n_tx;
        k = n_done + n_fail;
        tick(150);
        chk("post_rst_no_tx", 96'(n_tx), 96'(base));
        chk("post_rst_no_verdict", 96'(n_done + n_fail), 96'(k));
        chk("post_rst_cache", 96'(cache_valid), 96'(0));

        chk("exp_tx_drained", 96'(exp_tx.size()), 96'(0));
        chk("exp_res_drained", 96'(exp_res.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arp_ctrl.md
# arp_ctrl

Sequencing controller for the Ethernet ARP path of the video-over-Ethernet link. It sits between the ARP receive parser, the ARP transmit framer and the UDP video sender.
- Answers every valid incoming ARP request with an ARP reply.
- Learns the peer MAC/IP into a single-entry cache.
- Resolves a destination IP on demand for the UDP sender, issuing broadcast ARP requests with timeout and bounded retry.

It owns the single ARP transmit framer and arbitrates it between reply and request traffic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd125_000_000 — cycles to wait for an ARP reply per attempt (1 s at 125 MHz).
- MAX_RETRY, 2 — additional request attempts after the first; total attempts = MAX_RETRY+1.

Ports:
- clk  in  1  GMII rx/tx clock, 125 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- arp_rx_done  in  1  one-cycle pulse from the ARP parser: valid ARP packet addressed to this board.
- arp_rx_type  in  1  0 = request, 1 = reply; valid with arp_rx_done.
- src_mac  in  48  sender MAC; valid with arp_rx_done.
- src_ip  in  32  sender IP; valid with arp_rx_done.
- resolve_req  in  1  one-cycle pulse: resolve resolve_ip.
- resolve_ip  in  32  target IP; sampled on resolve_req.
- resolve_done  out  1  one-cycle pulse: resolved_mac is valid for the requested IP.
- resolve_fail  out  1  one-cycle pulse: all attempts timed out.
- resolved_mac  out  48  MAC for the last successful resolve; held until the next resolve_done.
- cache_valid  out  1  cache entry holds a learned pair.
- cache_ip  out  32  cached IP.
- cache_mac  out  48  cached MAC.
- arp_tx_en  out  1  one-cycle start pulse to the ARP framer.
- arp_tx_type  out  1  0 = request, 1 = reply.
- des_mac  out  48  destination MAC for the framer (ff_ff_ff_ff_ff_ff for requests).
- des_ip  out  32  destination IP for the framer.
- arp_tx_done  in  1  one-cycle pulse from the framer: frame fully sent.

## Operation
- **Learning.** Every arp_rx_done (request or reply) writes src_mac/src_ip into the cache and sets cache_valid. The cache is overwritten unconditionally; there is a single entry.
- **Reply pending.** arp_rx_done with arp_rx_type=0 sets reply_pend and captures reply_mac/reply_ip. A later request overwrites the captured pair (latest wins).
- **Resolve pending.** resolve_req sets resolve_pend and captures tgt_ip. It is ignored while resolve_pend is set or a resolve is in progress (states WAIT_RESP, or TX issuing a request).
- **FSM states:** IDLE, TX, WAIT_RESP.
  - IDLE, priority order:
    1. reply_pend → issue reply (arp_tx_type=1, des_mac=reply_mac, des_ip=reply_ip), clear reply_pend, go TX.
    2. resolve_pend with cache_valid && cache_ip==tgt_ip → pulse resolve_done, resolved_mac=cache_mac, clear resolve_pend, stay IDLE.
    3. resolve_pend otherwise → issue request (arp_tx_type=0, des_mac=all-ones, des_ip=tgt_ip), clear resolve_pend, retry_cnt=0, go TX.
  - TX: wait for arp_tx_done. Return to WAIT_RESP if a resolve is in progress, else IDLE.
  - WAIT_RESP:
    - timer counts every cycle from first entry of the attempt.
    - arp_rx_done with arp_rx_type=1 and src_ip==tgt_ip → resolve_done, resolved_mac=src_mac, go IDLE.
    - timer==TIMEOUT_CYCLES-1:
      - retry_cnt<MAX_RETRY → retry_cnt+1, timer=0, reissue request, go TX.
      - otherwise → resolve_fail, go IDLE.
    - reply_pend → issue reply, go TX (timer keeps running; a timeout during TX is acted on on return).
- A reply from a non-matching IP updates the cache only.
- Simultaneous arp_rx_done and resolve_req in the same cycle: both are latched.
- Reset mid-operation: everything returns to reset state, pending flags are cleared, and no done or fail pulse is emitted.

## Timing
- Reset values: all outputs 0 (resolved_mac, cache_ip, cache_mac, des_mac, des_ip = 0; arp_tx_type = 0).
- Pending flags are registered at the edge ending the input-pulse cycle N. The FSM acts in cycle N+1, and output pulses are high in cycle N+2.
- arp_tx_en is exactly one cycle wide. arp_tx_type, des_mac and des_ip are stable from the arp_tx_en cycle until arp_tx_done.
- A matching reply in WAIT_RESP at cycle N gives resolve_done at N+1, with the cache updated at the same edge.
- Timer is 32 bits and resets to 0 on each request issue.

## Test plan
- **ARP request reply.** Request from ip c0a80102 / mac a0b1c2d3e4f5 at cycle 10 → arp_tx_en at 12, type=1, des_mac=a0b1c2d3e4f5, des_ip=c0a80102; cache_valid=1, cache_ip=c0a80102.
- **Cache hit.** After the previous test, resolve_req ip=c0a80102 → resolve_done 2 cycles later, resolved_mac=a0b1c2d3e4f5, no arp_tx_en.
- **Cache miss.** resolve_req ip=c0a80103 → request with des_mac=ffffffffffff. Framer acks arp_tx_done after 60 cycles. Reply from c0a80103/112233445566 → resolve_done one cycle later, resolved_mac=112233445566.
- **Retry exhaustion.** TIMEOUT_CYCLES=100, MAX_RETRY=2, no reply → exactly 3 arp_tx_en pulses about 100 cycles apart, then one resolve_fail, state IDLE.
- **Reply during resolve.** In WAIT_RESP, inject an ARP request → reply issued with type=1; the later matching reply still yields resolve_done.
- **Reset mid-operation.** Assert rst_n low during TX → all outputs 0; after release no pulses appear until new stimulus.
